axil_reg_responder: RTL
=======================

AXIL_REG_RESPONDER -- requirements
Module: axil_reg_responder

Interface
REQ-001 SHALL have parameter C_ADDR_WIDTH, default 6, byte-address width (16-word decode space).
REQ-002 SHALL have parameter C_DATA_WIDTH, default 32, data width; only 32 is supported.
REQ-003 SHALL have port ACLK  in  1  sole clock; all logic is rising-edge.
REQ-004 SHALL have port ARESET  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports AWADDR in C_ADDR_WIDTH, AWPROT in 3 (ignored), AWVALID in 1, AWREADY out 1.
REQ-006 SHALL have ports WDATA in 32, WSTRB in 4, WVALID in 1, WREADY out 1.
REQ-007 SHALL have ports BRESP out 2, BVALID out 1, BREADY in 1.
REQ-008 SHALL have ports ARADDR in C_ADDR_WIDTH, ARPROT in 3 (ignored), ARVALID in 1, ARREADY out 1.
REQ-009 SHALL have ports RDATA out 32, RRESP out 2, RVALID out 1, RREADY in 1.

Function
REQ-010 SHALL implement four 32-bit read/write registers at word offsets 0x0, 0x4, 0x8 and 0xC; address bits [1:0] are ignored.
REQ-011 SHALL treat word index >= 4 as a decode error: writes are discarded with BRESP=SLVERR (2'b10); reads return RDATA=0 with RRESP=SLVERR; otherwise the response is OKAY (2'b00).
REQ-012 SHALL use write FSM states W_IDLE, W_ADDR (AW held), W_DATA (W held), W_RESP (BVALID high).
REQ-013 SHALL accept AW and W independently, in either order or in the same cycle: AWREADY is high in W_IDLE and W_DATA, and WREADY is high in W_IDLE and W_ADDR.
REQ-014 SHALL register AWADDR and WDATA/WSTRB on their respective handshakes.
REQ-015 SHALL commit the write and enter W_RESP on the edge at which the second of AW/W is accepted, so that BVALID rises 1 cycle after that handshake.
REQ-016 SHALL update only the bytes whose WSTRB bit is set; WSTRB=0 leaves the register unchanged and still responds OKAY.
REQ-017 SHALL hold BVALID and BRESP stable until BREADY, then return to W_IDLE; AWREADY=WREADY=0 throughout W_RESP, giving one outstanding write.
REQ-018 SHALL use read FSM states R_IDLE (ARREADY=1) and R_RESP (RVALID=1, ARREADY=0).
REQ-019 SHALL register RDATA and RRESP on the ARVALID&ARREADY edge, so that RVALID rises 1 cycle after the handshake.
REQ-020 SHALL hold RVALID, RDATA and RRESP stable until RREADY.
REQ-021 SHALL keep the read and write paths fully concurrent.
REQ-022 SHALL, when a read handshake and a write commit target the same register on the same edge, return the pre-write value in RDATA.
REQ-023 SHALL make BVALID, RVALID, AWREADY, WREADY, ARREADY, BRESP, RRESP and RDATA all flop outputs, with no combinational input-to-output paths.
REQ-024 SHALL not depend on VALID being deasserted after a handshake; a back-to-back VALID is accepted as a new transaction once READY returns.

Reset
REQ-025 SHALL, while ARESET=1, force every output to 0, all four registers to 0x00000000, and both FSMs to their IDLE states.
REQ-026 SHALL raise AWREADY, WREADY and ARREADY on the first ACLK edge after ARESET deasserts.
REQ-027 SHALL, on ARESET asserted mid-transaction, drop any held AW/W and any pending B/R response: BVALID and RVALID go low asynchronously and no register write commits.

Structure
REQ-028 SHALL take the following from a shared package axil_reg_pkg: RESP_OKAY and RESP_SLVERR constants, NUM_REGS=4, and the write/read state enums.
REQ-029 SHALL place the register array with byte-strobe write and combinational read port in one sub-module, axil_reg_file; handshake FSMs stay in the top.

Verification
REQ-030 Sequential write then read: write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then read 0x0..0xC -> RDATA 0x1..0x4, all BRESP/RRESP=OKAY.
REQ-031 W before AW: WVALID asserted 3 cycles before AWVALID (addr 0x8, data 0xA5A5A5A5) -> WREADY drops after the W handshake, BVALID rises 1 cycle after the AW handshake, and a readback returns 0xA5A5A5A5.
REQ-032 Byte strobe: reg 0 = 0xFFFFFFFF, then write 0x12345678 with WSTRB=4'b0101 -> readback 0xFF34FF78.
REQ-033 Decode error and backpressure: write to 0x10 with BREADY held low for 5 cycles -> BVALID/BRESP=SLVERR stable and AWREADY=0 for all 5 cycles; a read of 0x3C returns RDATA=0 with RRESP=SLVERR.
REQ-034 Reset mid-op: ARESET pulsed while BVALID=1 and RVALID=1 -> both drop immediately, all registers read 0x0 afterwards, and the readies return 1 cycle after deassertion.
REQ-035 Same-edge collision: reg 4'h4 = 0x11, then AR to 0x4 on the same edge as a write commit of 0x22 -> RDATA=0x11, and a subsequent read returns 0x22.

Source files
------------

// File: rtl/axil_reg_pkg.sv
// Shared constants and FSM state types for the AXI4-Lite register responder.
package axil_reg_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int NUM_REGS = 4;
  localparam int REG_AW   = 2;
  localparam int DATA_W   = 32;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_t;

endpackage

// File: rtl/axil_reg_file.sv
// Four 32-bit registers with byte-strobed synchronous write and combinational read.
module axil_reg_file
  import axil_reg_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_we,
  input  logic [REG_AW-1:0]   i_widx,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_wstrb,
  input  logic [REG_AW-1:0]   i_ridx,
  output logic [DATA_W-1:0]   o_rdata
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (i_we) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (i_wstrb[b]) r_regs[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  // Read sees the pre-write value when a write lands on the same edge.
  assign o_rdata = r_regs[i_ridx];

endmodule

// File: rtl/axil_reg_responder.sv
// AXI4-Lite slave exposing four registers; independent write and read FSMs,
// one outstanding transaction per direction, all outputs registered.
module axil_reg_responder
  import axil_reg_pkg::*;
#(
  parameter int C_ADDR_WIDTH = 6,
  parameter int C_DATA_WIDTH = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [C_ADDR_WIDTH-1:0]   AWADDR,
  input  logic [2:0]                AWPROT,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  input  logic [C_DATA_WIDTH-1:0]   WDATA,
  input  logic [C_DATA_WIDTH/8-1:0] WSTRB,
  input  logic                      WVALID,
  output logic                      WREADY,
  output logic [1:0]                BRESP,
  output logic                      BVALID,
  input  logic                      BREADY,
  input  logic [C_ADDR_WIDTH-1:0]   ARADDR,
  input  logic [2:0]                ARPROT,
  input  logic                      ARVALID,
  output logic                      ARREADY,
  output logic [C_DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]                RRESP,
  output logic                      RVALID,
  input  logic                      RREADY
);

  localparam int IDX_W = C_ADDR_WIDTH - 2;

  wr_state_t                 r_wr_state, w_wr_next;
  rd_state_t                 r_rd_state;
  logic [IDX_W-1:0]          w_aw_idx, w_ar_idx, r_aw_idx, w_c_idx;
  logic [C_DATA_WIDTH-1:0]   r_wdata, w_c_data, r_rdata, w_rf_rdata;
  logic [C_DATA_WIDTH/8-1:0] r_wstrb, w_c_strb;
  logic                      r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
  logic [1:0]                r_bresp, r_rresp;
  logic                      w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_c_ok, w_ar_ok;
  logic                      w_unused;

  assign w_unused = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};

  assign w_aw_idx = AWADDR[C_ADDR_WIDTH-1:2];
  assign w_ar_idx = ARADDR[C_ADDR_WIDTH-1:2];
  assign w_aw_hs  = AWVALID & r_awready;
  assign w_w_hs   = WVALID & r_wready;
  assign w_ar_hs  = ARVALID & r_arready;
  assign w_c_ok   = (w_c_idx < IDX_W'(NUM_REGS));
  assign w_ar_ok  = (w_ar_idx < IDX_W'(NUM_REGS));

  // Commit operands come from the live bus for whichever half arrives last.
  always_comb begin
    w_wr_next = r_wr_state;
    w_commit  = 1'b0;
    w_c_idx   = w_aw_idx;
    w_c_data  = WDATA;
    w_c_strb  = WSTRB;
    case (r_wr_state)
      W_IDLE: begin
        if (w_aw_hs && w_w_hs) begin
          w_commit  = 1'b1;
          w_wr_next = W_RESP;
        end else if (w_aw_hs) begin
          w_wr_next = W_ADDR;
        end else if (w_w_hs) begin
          w_wr_next = W_DATA;
        end
      end
      W_ADDR: begin
        w_c_idx = r_aw_idx;
        if (w_w_hs) begin
          w_commit  = 1'b1;
          w_wr_next = W_RESP;
        end
      end
      W_DATA: begin
        w_c_data = r_wdata;
        w_c_strb = r_wstrb;
        if (w_aw_hs) begin
          w_commit  = 1'b1;
          w_wr_next = W_RESP;
        end
      end
      W_RESP: begin
        if (BREADY) w_wr_next = W_IDLE;
      end
      default: w_wr_next = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_wr_state <= W_IDLE;
      r_aw_idx   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
    end else begin
      r_wr_state <= w_wr_next;
      if (w_aw_hs) r_aw_idx <= w_aw_idx;
      if (w_w_hs) begin
        r_wdata <= WDATA;
        r_wstrb <= WSTRB;
      end
      r_awready <= (w_wr_next == W_IDLE) || (w_wr_next == W_DATA);
      r_wready  <= (w_wr_next == W_IDLE) || (w_wr_next == W_ADDR);
      r_bvalid  <= (w_wr_next == W_RESP);
      if (w_commit) r_bresp <= w_c_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_rd_state <= R_IDLE;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
    end else begin
      case (r_rd_state)
        R_IDLE: begin
          r_arready <= 1'b1;
          if (w_ar_hs) begin
            r_rd_state <= R_RESP;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b1;
            r_rdata    <= w_ar_ok ? w_rf_rdata : '0;
            r_rresp    <= w_ar_ok ? RESP_OKAY : RESP_SLVERR;
          end
        end
        R_RESP: begin
          if (RREADY) begin
            r_rd_state <= R_IDLE;
            r_rvalid   <= 1'b0;
            r_arready  <= 1'b1;
          end
        end
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

  axil_reg_file u_reg_file (
    .i_clk   (ACLK),
    .i_rst   (ARESET),
    .i_we    (w_commit & w_c_ok),
    .i_widx  (w_c_idx[REG_AW-1:0]),
    .i_wdata (w_c_data),
    .i_wstrb (w_c_strb),
    .i_ridx  (w_ar_idx[REG_AW-1:0]),
    .o_rdata (w_rf_rdata)
  );

  assign AWREADY = r_awready;
  assign WREADY  = r_wready;
  assign BVALID  = r_bvalid;
  assign BRESP   = r_bresp;
  assign ARREADY = r_arready;
  assign RVALID  = r_rvalid;
  assign RDATA   = r_rdata;
  assign RRESP   = r_rresp;

endmodule
